z88_bus_arbiter: RTL and testbench
==================================

Z88_BUS_ARBITER -- requirements
Module: z88_bus_arbiter

Interface
REQ-001 SHALL have one clock and synchronous active-low reset: clk (50 MHz master) and rst (active-low, sampled on posedge clk only).
REQ-002 Ports SHALL be:
- clk  in  1  master clock
- rst  in  1  synchronous reset, active-low
- clk_ena  out  1  12.5 MHz enable, one-cycle pulse every 4 clk
- bus_ph  out  1  slot owner: 0 LCD, 1 Z80
- lcd_rden  in  1  LCD fetch request
- lcd_addr  in  22  LCD address
- lcd_vld  out  1  LCD read data valid, one-cycle pulse
- lcd_rdata  out  8  LCD read data
- z80_rd  in  1  Z80 memory read request, held until z80_done
- z80_wr  in  1  Z80 memory write request, held until z80_done
- z80_addr  in  22  Z80 translated physical address
- z80_wdata  in  8  Z80 write data
- z80_rdata  out  8  Z80 read data
- z80_done  out  1  Z80 access complete, one-cycle pulse
- z80_wait  out  1  Z80 access pending
- mem_req  out  1  memory request, held until mem_ack or abort
- mem_we  out  1  memory write strobe qualifier
- mem_addr  out  22  memory address
- mem_wdata  out  8  memory write data
- mem_ack  in  1  memory acknowledge, one-cycle pulse
- mem_rdata  in  8  memory read data, valid with mem_ack
- mem_tmo  out  1  sticky timeout flag
- tmo_cnt  out  8  saturating timeout count

Function
REQ-003 2-bit divider ctr SHALL increment every clk; clk_ena SHALL be 1 in the cycle where ctr==3.
REQ-004 bus_ph SHALL toggle on the edge ending each clk_ena cycle; each slot lasts 4 clk (c0..c3), with c3 the clk_ena cycle.
REQ-005 In c0, the FSM SHALL be in IDLE and SHALL sample only the slot owner: bus_ph=0 -> lcd_rden; bus_ph=1 -> z80_wr or z80_rd.
REQ-006 Slots SHALL be strictly owned: a non-requesting owner leaves the slot idle, and no borrowing is allowed.
REQ-007 FSM states SHALL be IDLE, REQ and DONE.
- IDLE->REQ at the c0 edge if the owner requests; mem_addr, mem_we and mem_wdata are registered at that edge.
- REQ->DONE on mem_ack.
- REQ->IDLE on the c3 edge without ack (timeout).
- DONE->IDLE next edge.
REQ-008 mem_req SHALL be 1 exactly while in REQ, so it is visible c1..c3 at most; mem_ack is accepted in c1, c2 or c3.
REQ-009 LCD access SHALL use mem_we=0 and mem_addr=lcd_addr; on ack, lcd_rdata<=mem_rdata, and lcd_vld SHALL be 1 the cycle after ack.
REQ-010 Z80 access SHALL set mem_we=z80_wr and mem_addr=z80_addr.
- If z80_rd and z80_wr are both 1, the access SHALL be treated as a write.
- On ack: z80_rdata<=mem_rdata for reads (unchanged for writes), and z80_done=1 the cycle after ack.
REQ-011 z80_wait SHALL be 1 whenever (z80_rd|z80_wr) is 1 and z80_done is not being asserted in that cycle.
REQ-012 Once complete, a Z80 request still held in the next cycle SHALL NOT re-issue until the requester drops it for at least one cycle.
REQ-013 On timeout:
- mem_req drops, mem_tmo<=1 (sticky), and tmo_cnt increments, saturating at 255.
- LCD: lcd_vld SHALL NOT pulse.
- Z80: z80_rdata<=8'hFF, z80_done pulses the cycle after c3, and the access is not retried.
REQ-014 mem_ack while not in REQ SHALL be ignored.
REQ-015 lcd_vld and z80_done SHALL never be 1 in the same cycle.

Reset
REQ-016 While rst=0 on a clk edge, all of the following SHALL hold next cycle, regardless of any in-flight access:
- ctr=0, bus_ph=0, clk_ena=0, FSM=IDLE.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- lcd_vld=0, lcd_rdata=0, z80_rdata=0, z80_done=0.
- mem_tmo=0, tmo_cnt=0.
- z80_wait follows REQ-011.
REQ-017 After reset release, the first clk_ena SHALL occur in the 4th cycle, and the first slot SHALL be LCD (bus_ph=0).

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset release, no requests: clk_ena pulses every 4 clk; bus_ph toggles 0->1 after the first pulse; mem_req stays 0.
- lcd_rden=1, lcd_addr=22'h012345, memory acks in c2 with 8'hA5: mem_req high c1..c2, lcd_vld pulse in c3, lcd_rdata=8'hA5.
- z80_wr=1, addr 22'h3FFFFF, wdata 8'h5A during bus_ph=0: no access until the Z80 slot; mem_we=1; z80_done pulse; z80_wait falls on done.
- Z80 read, no ack: mem_req drops after c3; z80_rdata=8'hFF; z80_done pulses; mem_tmo=1; tmo_cnt=1.
- 300 forced timeouts: tmo_cnt saturates at 255.
- rst=0 asserted in c2 of an LCD access: mem_req=0 next cycle; no lcd_vld; all outputs at reset values.

Source files
------------

// File: rtl/z88_bus_arbiter.sv
// -----------------------------------------------------------------------------
// z88_bus_arbiter
//
// Time-slotted memory arbiter for the Z88 core. A free-running 2-bit divider
// splits the 50 MHz master clock into 4-cycle slots (c0..c3). The slots
// alternate strictly between the LCD fetcher (bus_ph=0) and the Z80
// (bus_ph=1). In c0 the current slot owner's request is sampled. If it is
// present, one memory request is issued and held until mem_ack, or until the
// end of c3, where the access times out.
//
// Ports
//   clk_i        in   1   master clock (50 MHz)
//   rst_i        in   1   synchronous reset, active-low
//   clk_ena_o    out  1   12.5 MHz enable, high in c3 of every slot
//   bus_ph_o     out  1   slot owner: 0 LCD, 1 Z80
//   lcd_rden_i   in   1   LCD fetch request (sampled in c0 of an LCD slot)
//   lcd_addr_i   in  22   LCD fetch address
//   lcd_vld_o    out  1   LCD read data valid, one-cycle pulse
//   lcd_rdata_o  out  8   LCD read data
//   z80_rd_i     in   1   Z80 read request, held until z80_done_o
//   z80_wr_i     in   1   Z80 write request, held until z80_done_o
//   z80_addr_i   in  22   Z80 physical address
//   z80_wdata_i  in   8   Z80 write data
//   z80_rdata_o  out  8   Z80 read data (8'hFF after a timed-out access)
//   z80_done_o   out  1   Z80 access complete, one-cycle pulse
//   z80_wait_o   out  1   Z80 access pending
//   mem_req_o    out  1   memory request, high while the FSM is in REQ
//   mem_we_o     out  1   memory write qualifier
//   mem_addr_o   out 22   memory address
//   mem_wdata_o  out  8   memory write data
//   mem_ack_i    in   1   memory acknowledge, one-cycle pulse
//   mem_rdata_i  in   8   memory read data, valid with mem_ack_i
//   mem_tmo_o    out  1   sticky timeout flag
//   tmo_cnt_o    out  8   saturating timeout counter
// -----------------------------------------------------------------------------
module z88_bus_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        clk_ena_o,
  output logic        bus_ph_o,
  input  logic        lcd_rden_i,
  input  logic [21:0] lcd_addr_i,
  output logic        lcd_vld_o,
  output logic [7:0]  lcd_rdata_o,
  input  logic        z80_rd_i,
  input  logic        z80_wr_i,
  input  logic [21:0] z80_addr_i,
  input  logic [7:0]  z80_wdata_i,
  output logic [7:0]  z80_rdata_o,
  output logic        z80_done_o,
  output logic        z80_wait_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [21:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        mem_tmo_o,
  output logic [7:0]  tmo_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slot timing
  logic [1:0]  ctr_q, ctr_d;
  logic        bus_ph_q, bus_ph_d;

  // Access FSM and the owner of the access in flight
  state_t      state_q, state_d;
  logic        owner_q, owner_d;

  // Memory-side registers
  logic        mem_we_q, mem_we_d;
  logic [21:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  // Requester-side registers
  logic        lcd_vld_q, lcd_vld_d;
  logic [7:0]  lcd_rdata_q, lcd_rdata_d;
  logic [7:0]  z80_rdata_q, z80_rdata_d;
  logic        z80_done_q, z80_done_d;
  logic        z80_blk_q, z80_blk_d;

  // Timeout bookkeeping
  logic        mem_tmo_q, mem_tmo_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic        slot_c0;
  logic        slot_c3;
  logic        z80_any;
  logic        owner_req;
  logic        start;

  assign slot_c0 = (ctr_q == 2'd0);
  assign slot_c3 = (ctr_q == 2'd3);
  assign z80_any = z80_rd_i | z80_wr_i;

  // Only the slot owner is looked at. A Z80 request that has already been
  // served stays blocked until the requester drops it, so a held request is
  // never issued twice.
  assign owner_req = bus_ph_q ? (z80_any & ~z80_blk_q) : lcd_rden_i;

  // The FSM can never be in REQ during c0, because every access ends by the
  // c3 edge. DONE may be left in c0 (ack in c3), and it samples like IDLE so
  // the following slot is not lost.
  assign start = slot_c0 & owner_req & (state_q != REQ);

  always_comb begin
    ctr_d       = ctr_q + 2'd1;
    bus_ph_d    = bus_ph_q ^ slot_c3;
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lcd_vld_d   = 1'b0;
    lcd_rdata_d = lcd_rdata_q;
    z80_rdata_d = z80_rdata_q;
    z80_done_d  = 1'b0;
    mem_tmo_d   = mem_tmo_q;
    tmo_cnt_d   = tmo_cnt_q;

    // Block is armed when a done pulse meets a still-held request. It is
    // released by any cycle with no Z80 request.
    if (!z80_any) begin
      z80_blk_d = 1'b0;
    end else if (z80_done_q) begin
      z80_blk_d = 1'b1;
    end else begin
      z80_blk_d = z80_blk_q;
    end

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = REQ;
          owner_d = bus_ph_q;
          if (bus_ph_q) begin
            // A simultaneous read and write is treated as a write.
            mem_we_d    = z80_wr_i;
            mem_addr_d  = z80_addr_i;
            mem_wdata_d = z80_wdata_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = lcd_addr_i;
            mem_wdata_d = 8'h00;
          end
        end
      end

      REQ: begin
        if (mem_ack_i) begin
          state_d = DONE;
          if (!owner_q) begin
            lcd_rdata_d = mem_rdata_i;
            lcd_vld_d   = 1'b1;
          end else begin
            if (!mem_we_q) begin
              z80_rdata_d = mem_rdata_i;
            end
            z80_done_d = 1'b1;
          end
        end else if (slot_c3) begin
          // Timeout: the LCD simply loses its fetch; the Z80 gets 8'hFF and
          // a completion so it is not left waiting forever.
          state_d   = IDLE;
          mem_tmo_d = 1'b1;
          if (tmo_cnt_q != 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
          if (owner_q) begin
            z80_rdata_d = 8'hFF;
            z80_done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctr_q       <= 2'd0;
      bus_ph_q    <= 1'b0;
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 22'd0;
      mem_wdata_q <= 8'h00;
      lcd_vld_q   <= 1'b0;
      lcd_rdata_q <= 8'h00;
      z80_rdata_q <= 8'h00;
      z80_done_q  <= 1'b0;
      z80_blk_q   <= 1'b0;
      mem_tmo_q   <= 1'b0;
      tmo_cnt_q   <= 8'h00;
    end else begin
      ctr_q       <= ctr_d;
      bus_ph_q    <= bus_ph_d;
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lcd_vld_q   <= lcd_vld_d;
      lcd_rdata_q <= lcd_rdata_d;
      z80_rdata_q <= z80_rdata_d;
      z80_done_q  <= z80_done_d;
      z80_blk_q   <= z80_blk_d;
      mem_tmo_q   <= mem_tmo_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign clk_ena_o   = slot_c3;
  assign bus_ph_o    = bus_ph_q;
  assign lcd_vld_o   = lcd_vld_q;
  assign lcd_rdata_o = lcd_rdata_q;
  assign z80_rdata_o = z80_rdata_q;
  assign z80_done_o  = z80_done_q;
  assign z80_wait_o  = z80_any & ~z80_done_q;
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_tmo_o   = mem_tmo_q;
  assign tmo_cnt_o   = tmo_cnt_q;

endmodule

// File: tb/tb_z88_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_z88_bus_arbiter
//
// Randomised bench for z88_bus_arbiter. The reference model works in terms of
// slots: cycle n since reset release is slot n/4, phase n%4, and owner
// (n/4)%2. An access that starts in c0 at cycle s shows mem_req from s+1
// until the cycle carrying the ack, or through s+3 if no ack comes. Its
// completion is seen the cycle after that. The memory responder lives in the
// bench and chooses the ack offset when the access starts.
// -----------------------------------------------------------------------------
module tb_z88_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clk_ena_o;
  logic        bus_ph_o;
  logic        lcd_rden_i;
  logic [21:0] lcd_addr_i;
  logic        lcd_vld_o;
  logic [7:0]  lcd_rdata_o;
  logic        z80_rd_i;
  logic        z80_wr_i;
  logic [21:0] z80_addr_i;
  logic [7:0]  z80_wdata_i;
  logic [7:0]  z80_rdata_o;
  logic        z80_done_o;
  logic        z80_wait_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [21:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_ack_i;
  logic [7:0]  mem_rdata_i;
  logic        mem_tmo_o;
  logic [7:0]  tmo_cnt_o;

  z88_bus_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clk_ena_o   (clk_ena_o),
    .bus_ph_o    (bus_ph_o),
    .lcd_rden_i  (lcd_rden_i),
    .lcd_addr_i  (lcd_addr_i),
    .lcd_vld_o   (lcd_vld_o),
    .lcd_rdata_o (lcd_rdata_o),
    .z80_rd_i    (z80_rd_i),
    .z80_wr_i    (z80_wr_i),
    .z80_addr_i  (z80_addr_i),
    .z80_wdata_i (z80_wdata_i),
    .z80_rdata_o (z80_rdata_o),
    .z80_done_o  (z80_done_o),
    .z80_wait_o  (z80_wait_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_tmo_o   (mem_tmo_o),
    .tmo_cnt_o   (tmo_cnt_o)
  );

  always #10 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n = 0;
  bit          postRst = 1'b1;
  bit          accActive = 1'b0;
  int          accStart = 0;
  bit          accOwner = 1'b0;
  logic [21:0] accAddr = '0;
  bit          accWe = 1'b0;
  logic [7:0]  accWdata = '0;
  int          ackAt = 0;
  logic [7:0]  ackData = '0;
  bit          expLcdVld = 1'b0;
  logic [7:0]  expLcdRdata = '0;
  bit          expZDone = 1'b0;
  logic [7:0]  expZRdata = '0;
  bit          expTmo = 1'b0;
  int          expCnt = 0;

  // Stimulus knobs
  bit          rstDrive = 1'b1;
  int          lcdMode = 0;
  bit          lcdAddrFixed = 1'b0;
  logic [21:0] lcdAddrFix = '0;
  int          ackMode = 0;
  int          ackFixed = 1;
  bit          ackDataFixedOn = 1'b0;
  logic [7:0]  ackDataFix = '0;
  bit          spurOn = 1'b0;
  bit          zEnable = 1'b0;
  bit          zForce = 1'b0;
  bit          zForceRd = 1'b0;
  bit          zForceWr = 1'b0;
  logic [21:0] zForceAddr = '0;
  logic [7:0]  zForceWdata = '0;

  // Z80 requester state
  bit          zHeld = 1'b0;
  bit          zServed = 1'b0;
  bit          zDoneSeen = 1'b0;
  bit          zRd = 1'b0;
  bit          zWr = 1'b0;
  logic [21:0] zAddr = '0;
  logic [7:0]  zWdata = '0;
  int          zLinger = 0;
  int          zGap = 0;

  // Pulses seen on the DUT outputs
  int          dutLcdVldCnt = 0;
  int          dutZDoneCnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag,
               observed, expected, n);
    end
  endtask

  // Advance the model across the clock edge that ends the current cycle.
  task automatic modelEdge();
    bit nextVld;
    bit nextDone;
    if (rstDrive) begin
      n = 0;
      postRst = 1'b1;
      accActive = 1'b0;
      expLcdVld = 1'b0;
      expLcdRdata = '0;
      expZDone = 1'b0;
      expZRdata = '0;
      expTmo = 1'b0;
      expCnt = 0;
      return;
    end
    postRst = 1'b0;
    nextVld = 1'b0;
    nextDone = 1'b0;
    if (accActive) begin
      if (ackAt != 0 && n == accStart + ackAt) begin
        accActive = 1'b0;
        if (!accOwner) begin
          expLcdRdata = ackData;
          nextVld = 1'b1;
        end else begin
          if (!accWe) expZRdata = ackData;
          nextDone = 1'b1;
        end
      end else if (ackAt == 0 && n == accStart + 3) begin
        accActive = 1'b0;
        expTmo = 1'b1;
        expCnt = (expCnt < 255) ? expCnt + 1 : 255;
        if (accOwner) begin
          expZRdata = 8'hFF;
          nextDone = 1'b1;
        end
      end
    end
    if (n % 4 == 0 && !accActive) begin
      if (((n / 4) % 2) == 0 && lcd_rden_i) begin
        accActive = 1'b1;
        accOwner = 1'b0;
        accAddr = lcd_addr_i;
        accWe = 1'b0;
        accWdata = '0;
      end else if (((n / 4) % 2) == 1 && zHeld && !zServed) begin
        accActive = 1'b1;
        accOwner = 1'b1;
        accAddr = zAddr;
        accWe = zWr;
        accWdata = zWdata;
        zServed = 1'b1;
      end
      if (accActive) begin
        accStart = n;
        case (ackMode)
          0: ackAt = $urandom_range(0, 3);
          1: ackAt = ackFixed;
          default: ackAt = 0;
        endcase
        ackData = ackDataFixedOn ? ackDataFix : 8'($urandom);
      end
    end
    expLcdVld = nextVld;
    expZDone = nextDone;
    n++;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check z80_wait,
  // then advance the model.
  task automatic applyStimulus();
    bit expReq;
    @(negedge clk_i);
    expReq = accActive && (n > accStart);
    checkOutput("clkEna", clk_ena_o, (n % 4 == 3));
    checkOutput("busPh", bus_ph_o, ((n / 4) % 2));
    checkOutput("memReq", mem_req_o, expReq);
    if (expReq) begin
      checkOutput("memAddr", mem_addr_o, accAddr);
      checkOutput("memWe", mem_we_o, accWe);
      if (accOwner) checkOutput("memWdata", mem_wdata_o, accWdata);
    end
    if (postRst) begin
      checkOutput("rstAddr", mem_addr_o, 0);
      checkOutput("rstWe", mem_we_o, 0);
      checkOutput("rstWdata", mem_wdata_o, 0);
    end
    checkOutput("lcdVld", lcd_vld_o, expLcdVld);
    checkOutput("lcdRdata", lcd_rdata_o, expLcdRdata);
    checkOutput("z80Done", z80_done_o, expZDone);
    checkOutput("z80Rdata", z80_rdata_o, expZRdata);
    checkOutput("memTmo", mem_tmo_o, expTmo);
    checkOutput("tmoCnt", tmo_cnt_o, expCnt);
    checkOutput("vldDoneExcl", lcd_vld_o & z80_done_o, 0);
    if (lcd_vld_o) dutLcdVldCnt++;
    if (z80_done_o) dutZDoneCnt++;

    rst_i = rstDrive ? 1'b0 : 1'b1;
    lcd_rden_i = (lcdMode == 2) ? 1'b1 : (lcdMode == 1) ? 1'($urandom) : 1'b0;
    lcd_addr_i = lcdAddrFixed ? lcdAddrFix : 22'($urandom);

    if (rstDrive) begin
      zHeld = 1'b0;
      zDoneSeen = 1'b0;
      zGap = 0;
    end else if (zHeld) begin
      if (expZDone) begin
        zDoneSeen = 1'b1;
        zLinger = zEnable ? $urandom_range(0, 4) : 0;
      end
      if (zDoneSeen) begin
        if (zLinger == 0) begin
          zHeld = 1'b0;
          zGap = $urandom_range(0, 4);
        end else begin
          zLinger--;
        end
      end
    end else if (zGap > 0) begin
      zGap--;
    end else if (zForce || (zEnable && $urandom_range(0, 2) == 0)) begin
      zHeld = 1'b1;
      zServed = 1'b0;
      zDoneSeen = 1'b0;
      if (zForce) begin
        zRd = zForceRd;
        zWr = zForceWr;
        zAddr = zForceAddr;
        zWdata = zForceWdata;
        zForce = 1'b0;
      end else begin
        case ($urandom_range(0, 2))
          0: begin zRd = 1'b1; zWr = 1'b0; end
          1: begin zRd = 1'b0; zWr = 1'b1; end
          default: begin zRd = 1'b1; zWr = 1'b1; end
        endcase
        zAddr = 22'($urandom);
        zWdata = 8'($urandom);
      end
    end
    z80_rd_i = zHeld & zRd;
    z80_wr_i = zHeld & zWr;
    z80_addr_i = zAddr;
    z80_wdata_i = zWdata;

    if (accActive && ackAt != 0 && n == accStart + ackAt) begin
      mem_ack_i = 1'b1;
      mem_rdata_i = ackData;
    end else begin
      mem_ack_i = spurOn && !expReq && ($urandom_range(0, 3) == 0);
      mem_rdata_i = 8'($urandom);
    end

    #1;
    checkOutput("z80Wait", z80_wait_o, (z80_rd_i | z80_wr_i) && !expZDone);
    modelEdge();
  endtask

  task automatic alignTo(input int phase8);
    for (int k = 0; k < 8 && (n % 8) != phase8; k++) applyStimulus();
  endtask

  initial begin
    int doneBefore;
    int vldBefore;
    bit found;

    rst_i = 1'b0;
    lcd_rden_i = 1'b0;
    lcd_addr_i = '0;
    z80_rd_i = 1'b0;
    z80_wr_i = 1'b0;
    z80_addr_i = '0;
    z80_wdata_i = '0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;

    $display("[TB] reset and idle slots");
    rstDrive = 1'b1;
    repeat (3) applyStimulus();
    rstDrive = 1'b0;
    repeat (16) applyStimulus();

    $display("[TB] LCD fetch acked in c2");
    alignTo(0);
    lcdMode = 2;
    lcdAddrFixed = 1'b1;
    lcdAddrFix = 22'h012345;
    ackMode = 1;
    ackFixed = 2;
    ackDataFixedOn = 1'b1;
    ackDataFix = 8'hA5;
    vldBefore = dutLcdVldCnt;
    applyStimulus();
    lcdMode = 0;
    repeat (5) applyStimulus();
    checkOutput("lcdRdataA5", lcd_rdata_o, 8'hA5);
    checkOutput("lcdVldOnce", dutLcdVldCnt - vldBefore, 1);
    lcdAddrFixed = 1'b0;
    ackDataFixedOn = 1'b0;

    $display("[TB] Z80 write raised in LCD slot");
    alignTo(1);
    zForce = 1'b1;
    zForceRd = 1'b0;
    zForceWr = 1'b1;
    zForceAddr = 22'h3FFFFF;
    zForceWdata = 8'h5A;
    ackFixed = 1;
    doneBefore = dutZDoneCnt;
    for (int k = 0; k < 32 && dutZDoneCnt == doneBefore; k++) applyStimulus();
    checkOutput("z80WrDone", dutZDoneCnt - doneBefore, 1);
    repeat (4) applyStimulus();

    $display("[TB] Z80 read with no ack");
    ackMode = 2;
    zForce = 1'b1;
    zForceRd = 1'b1;
    zForceWr = 1'b0;
    zForceAddr = 22'h00BEEF;
    doneBefore = dutZDoneCnt;
    for (int k = 0; k < 32 && dutZDoneCnt == doneBefore; k++) applyStimulus();
    checkOutput("z80TmoDone", dutZDoneCnt - doneBefore, 1);
    checkOutput("z80TmoRdata", z80_rdata_o, 8'hFF);
    checkOutput("tmoFlag", mem_tmo_o, 1);
    checkOutput("tmoCntOne", tmo_cnt_o, 1);
    repeat (4) applyStimulus();

    $display("[TB] forced LCD timeouts");
    lcdMode = 2;
    repeat (8 * 300) applyStimulus();
    checkOutput("tmoCntSat", tmo_cnt_o, 255);
    checkOutput("tmoSticky", mem_tmo_o, 1);

    $display("[TB] reset in c2 of an LCD access");
    ackMode = 1;
    ackFixed = 3;
    found = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      if (accActive && !accOwner && n == accStart + 2) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("rstFindC2", found, 1);
    vldBefore = dutLcdVldCnt;
    rstDrive = 1'b1;
    applyStimulus();
    lcdMode = 0;
    applyStimulus();
    checkOutput("rstMemReq", mem_req_o, 0);
    checkOutput("rstTmoCnt", tmo_cnt_o, 0);
    rstDrive = 1'b0;
    repeat (12) applyStimulus();
    checkOutput("rstNoLcdVld", dutLcdVldCnt - vldBefore, 0);

    $display("[TB] randomised traffic");
    lcdMode = 1;
    ackMode = 0;
    spurOn = 1'b1;
    zEnable = 1'b1;
    repeat (4000) applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
